// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbitration logic.
package uart_pkg;

  typedef enum logic [0:0] {IDLE, XFER} arb_state_t;

  localparam int unsigned UART_DATA_W = 8;

  // Widest requester vector rr_pick can search.
  localparam int unsigned RR_MAX_N = 16;

  // Round-robin pick: first set bit of req[n-1:0], searching upward from (ptr+1) mod n
  // with wrap-around. Returns ptr when nothing is requested.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX_N-1:0] req,
                                         input logic [3:0]          ptr,
                                         input logic [4:0]          n);
    logic [4:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= int'(RR_MAX_N); i++) begin
      idx = {1'b0, ptr} + 5'(i);
      // ptr < n and i <= n keep idx below 2n, so one subtraction is a full modulo.
      if (idx >= n) idx = idx - n;
      if (!found && (i <= int'(n)) && req[idx[3:0]]) begin
        rr_pick = idx[3:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority picker: lowest index above ptr wins, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  // Search order starts just after the previous owner.
  always_comb begin
    idx = IdxW'(rr_pick(RR_MAX_N'(req), 4'(ptr), 5'(N)));
    any = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte interface between N_REQ requesters.
// The owner keeps the grant until a last-flagged byte or MAX_BURST bytes have moved.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned DATA_W    = UART_DATA_W,
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned IdxW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [IdxW-1:0]         grant_id,
  output logic                    busy
);

  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic              own_valid;
  logic              own_last;
  logic [DATA_W-1:0] own_data;
  logic              xfer_fire;
  logic              xfer_release;

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Select the owner's valid/last/data lanes.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A byte moves when the owner and the core agree; release on last or at the burst cap.
  always_comb begin
    xfer_fire    = (state_q == XFER) && own_valid && tx_ready;
    xfer_release = xfer_fire && (own_last || (cnt_q == CntW'(MAX_BURST - 1)));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = XFER;
      XFER:    if (xfer_release) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner, burst counter and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= '0;
      rr_ptr_q <= IdxW'(N_REQ - 1);
      cnt_q    <= '0;
    end else begin
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Latch the winner on grant; count bytes; hand priority past the owner on release.
  always_comb begin
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE) begin
      if (pick_any) begin
        owner_d = pick_idx;
        cnt_d   = '0;
      end
    end else if (xfer_fire) begin
      cnt_d = cnt_q + CntW'(1);
      if (xfer_release) rr_ptr_d = owner_q;
    end
  end

  // Datapath is a pure mux from the owner; nothing is buffered.
  always_comb begin
    req_ready = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    busy      = (state_q == XFER);
    grant_id  = owner_q;
    if (state_q == XFER) begin
      tx_valid = own_valid;
      tx_data  = own_valid ? own_data : '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (owner_q == IdxW'(i)) req_ready[i] = tx_ready;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a driver feeds per-requester byte queues,
// a reference model pushes expected grants/bytes, and a monitor pops and compares.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready = 1'b0;
  logic [IW-1:0]   grant_id;
  logic            busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Source byte stores: {last, data} per requester.
  logic [8:0]   src_mem [N][512];
  int           head [N];
  int           tail [N];
  logic [N-1:0] stall = '0;
  bit           rand_stall = 0;
  int           tr_mode = 0;
  int           cyc = 0;

  // Reference model state.
  bit  m_busy = 0;
  int  m_owner = 0;
  int  m_cnt = 0;
  int  m_ptr = N - 1;
  bit  cyc_busy = 0;
  int  cyc_owner = 0;

  logic [IW+DW-1:0] exp_q[$];
  int               grant_q[$];
  int               hist[$];
  int               exp_h[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int r, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      src_mem[r][tail[r]] = {(k == len - 1), 8'(base + k)};
      tail[r]++;
    end
  endtask

  // Spec-level behaviour: grant the first valid requester after the last owner,
  // then pass the owner's bytes until a last byte or MB bytes.
  task automatic model_step();
    bit found;
    cyc_busy  = m_busy;
    cyc_owner = m_owner;
    if (!m_busy) begin
      if (req_valid != '0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            found   = 1;
          end
        end
        m_cnt  = 0;
        m_busy = 1;
        grant_q.push_back(m_owner);
      end
    end else if (req_valid[m_owner] && tx_ready) begin
      exp_q.push_back({IW'(m_owner), req_data[m_owner*DW +: DW]});
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MB) begin
        m_ptr  = m_owner;
        m_busy = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    case (tr_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom % 3) != 0;
      default: tx_ready = (cyc % 1042) == 0;
    endcase
    if (rand_stall) for (int i = 0; i < N; i++) stall[i] = ($urandom % 5) == 0;
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i] && !stall[i]) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[i*DW +: DW]} = src_mem[i][head[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'($urandom);
        req_data[i*DW +: DW] = 8'($urandom);
      end
    end
    #1 model_step();
    #2;
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) head[i]++;
  endtask

  function automatic bit pending();
    pending = m_busy;
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) pending = 1;
  endfunction

  task automatic drain(input int limit);
    int n = 0;
    while (pending() && n < limit) begin
      step();
      n++;
    end
    if (pending()) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: still pending after %0d cycles, required idle", limit);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_grant_id"}, grant_id, 0);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    #1 check_reset_outputs(tag);
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = N - 1;
    cyc_busy = 0; cyc_owner = 0;
    exp_q.delete();
    grant_q.delete();
    stall = '0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_hist(input string tag);
    check({tag, "_grant_count"}, hist.size(), exp_h.size());
    for (int k = 0; k < exp_h.size() && k < hist.size(); k++)
      check({tag, "_grant_order"}, hist[k], exp_h[k]);
  endtask

  // Monitor: pops the scoreboard whenever the DUT grants or moves a byte.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    logic [IW+DW-1:0] e;
    int g;
    #2;
    if (rst_n) begin
      check("busy", busy, cyc_busy);
      if (busy && !prev_busy) begin
        if (grant_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got grant_id %0d, required no grant", grant_id);
        end else begin
          g = grant_q.pop_front();
          check("grant_id", grant_id, g);
        end
        hist.push_back(int'(grant_id));
      end
      if (cyc_busy) begin
        check("grant_hold", grant_id, cyc_owner);
        check("tx_valid", tx_valid, req_valid[cyc_owner]);
        check("req_ready", req_ready, tx_ready ? (32'd1 << cyc_owner) : 32'd0);
      end else begin
        check("idle_tx_valid", tx_valid, 0);
        check("idle_req_ready", req_ready, 0);
      end
      if (!tx_valid) check("tx_data_gated", tx_data, 0);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h from %0d, required none", tx_data, grant_id);
        end else begin
          e = exp_q.pop_front();
          check("byte", {grant_id, tx_data}, e);
        end
      end
      prev_busy = busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end

    // Power-on reset.
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, three bytes.
    hist.delete();
    add_pkt(2, 3, 8'h41);
    drain(100);
    exp_h = {2};
    check_hist("single");

    // Round robin from reset: 0, 1, 3, then 0 again.
    async_reset("rr_rst");
    hist.delete();
    add_pkt(0, 1, 8'h10); add_pkt(1, 1, 8'h20); add_pkt(3, 1, 8'h30);
    drain(100);
    add_pkt(0, 1, 8'h11);
    drain(100);
    exp_h = {0, 1, 3, 0};
    check_hist("rr");

    // Burst cap: req 1 streams 10 bytes while req 0 competes.
    async_reset("burst_rst");
    hist.delete();
    add_pkt(1, 10, 8'h50);
    step();
    add_pkt(0, 1, 8'h80); add_pkt(0, 1, 8'h81);
    drain(200);
    exp_h = {1, 0, 1, 0, 1};
    check_hist("burst");

    // Backpressure: the core accepts one byte every 1042 cycles.
    tr_mode = 2;
    add_pkt(3, 3, 8'hA0); add_pkt(1, 2, 8'hB0);
    drain(12000);
    tr_mode = 0;

    // Mid-packet stall while req 3 waits.
    async_reset("stall_rst");
    hist.delete();
    add_pkt(1, 3, 8'hC0); add_pkt(3, 1, 8'hD0);
    n = 0;
    while (head[1] == 0 && n < 50) begin step(); n++; end
    check("stall_first_byte", head[1], 1);
    stall[1] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      check("stall_grant", grant_id, 1);
      check("stall_tx_valid", tx_valid, 0);
    end
    stall[1] = 1'b0;
    drain(100);
    exp_h = {1, 3};
    check_hist("stall");

    // Asynchronous reset on byte 2 of 5, then requester 0 wins first.
    async_reset("pre_rst");
    add_pkt(2, 5, 8'hE0);
    n = 0;
    while (head[2] == 0 && n < 50) begin step(); n++; end
    check("mid_busy", busy, 1);
    async_reset("mid_rst");
    hist.delete();
    add_pkt(3, 1, 8'hF3); add_pkt(2, 1, 8'hF2); add_pkt(0, 1, 8'hF0);
    drain(100);
    check("post_rst_count", hist.size(), 3);
    if (hist.size() > 0) check("post_rst_winner", hist[0], 0);

    // Randomized traffic with random stalls and backpressure.
    tr_mode    = 1;
    rand_stall = 1;
    for (int c = 0; c < 800; c++) begin
      if (($urandom % 8) == 0) begin
        n = $urandom_range(N - 1, 0);
        if (tail[n] < 450) add_pkt(n, $urandom_range(10, 1), $urandom_range(255, 0));
      end
      step();
    end
    rand_stall = 0;
    stall      = '0;
    drain(3000);

    step();
    check("exp_q_empty", exp_q.size(), 0);
    check("grant_q_empty", grant_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
